// File: rtl/bias_loader.sv
// Bias RAM loader: streams DEPTH bytes over valid/ready into a registered RAM write port,
// tracking completion, a sticky loaded flag and an additive checksum per session.
module bias_loader #(
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              loaded_o,
  output logic [DATA_W-1:0] checksum_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] count_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] checksum_q;
  logic              loaded_q;

  // Session control and write-port registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      checksum_q <= '0;
      loaded_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= LOAD;
            count_q    <= '0;
            checksum_q <= '0;
            loaded_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (valid_i) begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= count_q;
            wr_data_q  <= data_i;
            checksum_q <= checksum_q + data_i;
            // Park the counter at zero after the last entry so it never addresses past DEPTH-1
            if (count_q == LAST_ADDR) begin
              count_q <= '0;
              state_q <= DONE;
            end else begin
              count_q <= count_q + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          loaded_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status decodes of the state register
  assign ready_o    = (state_q == LOAD);
  assign busy_o     = (state_q == LOAD);
  assign done_o     = (state_q == DONE);
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign loaded_o   = loaded_q;
  assign checksum_o = checksum_q;

endmodule
